// File: rtl/spi_ram_ctrl.sv
// SPI-command / local-requester front end for a single-port RAM.
// SPI words load address registers or queue one access in a one-entry
// pending buffer; a round-robin FSM shares the memory port with a local
// requester and returns read data to whichever side issued the read.
module spi_ram_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // SPI slave side
   input  logic [9:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   // local requester
   input  logic              loc_req,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [DATA_W-1:0] loc_wdata,
   output logic              loc_gnt,
   output logic [DATA_W-1:0] loc_rdata,
   output logic              loc_rvalid,
   // single-port memory
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // sticky overflow
   output logic              ovf
);

   typedef enum logic [1:0] {
      StIdle,
      StSpiAcc,
      StLocAcc,
      StRdRet
   } state_e;

   localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e              state_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                pend_valid_q;
   logic                pend_we_q;
   logic [ADDR_W-1:0]   pend_addr_q;
   logic [DATA_W-1:0]   pend_data_q;
   logic                last_loc_q;   // 1: local was granted most recently
   logic                owner_loc_q;  // 1: current access belongs to local

   logic                grant_spi;
   logic                grant_loc;
   logic                cmd_access;
   logic                cmd_load;
   logic                cmd_accept;
   logic                cmd_drop;

   // Arbitration in IDLE and SPI command classification
   always_comb begin
      grant_spi = 1'b0;
      grant_loc = 1'b0;
      if (state_q == StIdle) begin
         if (pend_valid_q && loc_req) begin
            if (last_loc_q) grant_spi = 1'b1;
            else            grant_loc = 1'b1;
         end else if (pend_valid_q) begin
            grant_spi = 1'b1;
         end else if (loc_req) begin
            grant_loc = 1'b1;
         end
      end
      // bit 8 set: 01 write / 11 read; clear: 00 / 10 address loads
      cmd_access = rx_valid & rx_data[8];
      cmd_load   = rx_valid & ~rx_data[8];
      // a full buffer still accepts if it is being drained on this edge
      cmd_accept = cmd_access & (~pend_valid_q | grant_spi);
      cmd_drop   = cmd_access & ~cmd_accept;
   end

   // Address registers, pending buffer and overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         ovf          <= 1'b0;
      end else begin
         if (grant_spi) begin
            pend_valid_q <= 1'b0;
         end
         if (cmd_load) begin
            if (rx_data[9]) rd_addr_q <= rx_data[ADDR_W-1:0];
            else            wr_addr_q <= rx_data[ADDR_W-1:0];
         end
         if (cmd_accept) begin
            pend_valid_q <= 1'b1;
            pend_we_q    <= ~rx_data[9];
            pend_data_q  <= rx_data[DATA_W-1:0];
            if (rx_data[9]) begin
               pend_addr_q <= rd_addr_q;
               rd_addr_q   <= rd_addr_q + AddrOne;
            end else begin
               pend_addr_q <= wr_addr_q;
               wr_addr_q   <= wr_addr_q + AddrOne;
            end
         end
         if (cmd_drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // Access FSM with registered memory, grant and return-data outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_loc_q  <= 1'b1;
         owner_loc_q <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         loc_gnt     <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         loc_rdata   <= '0;
         loc_rvalid  <= 1'b0;
      end else begin
         // strobes default low; only set on the edge entering their cycle
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         loc_gnt    <= 1'b0;
         tx_valid   <= 1'b0;
         loc_rvalid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_spi) begin
                  state_q     <= StSpiAcc;
                  mem_en      <= 1'b1;
                  mem_we      <= pend_we_q;
                  mem_addr    <= pend_addr_q;
                  mem_wdata   <= pend_data_q;
                  last_loc_q  <= 1'b0;
                  owner_loc_q <= 1'b0;
               end else if (grant_loc) begin
                  state_q     <= StLocAcc;
                  mem_en      <= 1'b1;
                  mem_we      <= loc_we;
                  mem_addr    <= loc_addr;
                  mem_wdata   <= loc_wdata;
                  loc_gnt     <= 1'b1;
                  last_loc_q  <= 1'b1;
                  owner_loc_q <= 1'b1;
               end
            end
            StSpiAcc, StLocAcc: begin
               // mem_we still holds the type of the access just issued
               state_q <= mem_we ? StIdle : StRdRet;
            end
            StRdRet: begin
               if (owner_loc_q) begin
                  loc_rdata  <= mem_rdata;
                  loc_rvalid <= 1'b1;
               end else begin
                  tx_data  <= mem_rdata[7:0];
                  tx_valid <= 1'b1;
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl with a behavioural RAM.
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       loc_req;
   logic       loc_we;
   logic [7:0] loc_addr;
   logic [7:0] loc_wdata;
   logic       loc_gnt;
   logic [7:0] loc_rdata;
   logic       loc_rvalid;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       ovf;

   int n_checks = 0;
   int n_errors = 0;
   int tx_cnt   = 0;
   int tx0;
   int n;

   logic [7:0]  mem [256];
   logic [17:0] acc_q [$];   // {loc_gnt, we, addr, wdata} per memory access

   always #5 clk = ~clk;

   spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .loc_req   (loc_req),
      .loc_we    (loc_we),
      .loc_addr  (loc_addr),
      .loc_wdata (loc_wdata),
      .loc_gnt   (loc_gnt),
      .loc_rdata (loc_rdata),
      .loc_rvalid(loc_rvalid),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .ovf       (ovf)
   );

   // single-port RAM model, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   // access log and tx strobe counter
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en)   acc_q.push_back({loc_gnt, mem_we, mem_addr, mem_wdata});
         if (tx_valid) tx_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic l, input logic w, input logic [7:0] a,
                                      input logic [7:0] d);
      return {14'd0, l, w, a, d};
   endfunction

   function automatic logic [31:0] get(input int i);
      if (i < acc_q.size()) return 32'(acc_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic spi_drive(input logic [1:0] c, input logic [7:0] p);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = {c, p};
   endtask

   task automatic spi_end();
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic spi_cmd(input logic [1:0] c, input logic [7:0] p);
      spi_drive(c, p);
      spi_end();
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic loc_set(input logic w, input logic [7:0] a, input logic [7:0] d);
      loc_req   = 1'b1;
      loc_we    = w;
      loc_addr  = a;
      loc_wdata = d;
   endtask

   // wait (bounded) for the grant, then release the request
   task automatic wait_gnt(input string tag);
      int k = 0;
      while (!loc_gnt && k < 20) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, loc_gnt}, 32'd1);
      loc_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem_rdata = 8'h00;
      rx_valid  = 1'b0;
      rx_data   = '0;
      loc_req   = 1'b0;
      loc_we    = 1'b0;
      loc_addr  = '0;
      loc_wdata = '0;
      rst_n     = 1'b0;
      #1;
      check("rst_strobes", {26'd0, mem_en, mem_we, loc_gnt, tx_valid, loc_rvalid, ovf}, 32'd0);
      check("rst_data", {tx_data, loc_rdata, mem_addr, mem_wdata}, 32'd0);
      idle(2);
      rst_n = 1'b1;

      // round-robin ties: SPI first after reset, then alternate
      spi_cmd(2'b00, 8'h20);
      acc_q.delete();
      spi_drive(2'b01, 8'h11);
      spi_end();
      loc_set(1'b1, 8'h30, 8'h22);
      wait_gnt("rr_gnt1");
      idle(4);
      spi_drive(2'b01, 8'h33);
      spi_end();
      loc_set(1'b1, 8'h31, 8'h44);
      wait_gnt("rr_gnt2");
      idle(4);
      spi_cmd(2'b01, 8'h55);
      idle(4);
      spi_drive(2'b01, 8'h66);
      spi_end();
      loc_set(1'b1, 8'h32, 8'h77);
      wait_gnt("rr_gnt3");
      idle(5);
      check("rr_count", acc_q.size(), 32'd7);
      check("rr_0_spi", get(0), mk(1'b0, 1'b1, 8'h20, 8'h11));
      check("rr_1_loc", get(1), mk(1'b1, 1'b1, 8'h30, 8'h22));
      check("rr_2_spi", get(2), mk(1'b0, 1'b1, 8'h21, 8'h33));
      check("rr_3_loc", get(3), mk(1'b1, 1'b1, 8'h31, 8'h44));
      check("rr_4_spi", get(4), mk(1'b0, 1'b1, 8'h22, 8'h55));
      check("rr_5_loc", get(5), mk(1'b1, 1'b1, 8'h32, 8'h77));
      check("rr_6_spi", get(6), mk(1'b0, 1'b1, 8'h23, 8'h66));

      // SPI write then read back, latency from the 11 strobe
      spi_cmd(2'b00, 8'h10);
      acc_q.delete();
      spi_drive(2'b01, 8'hA5);
      spi_drive(2'b10, 8'h10);
      spi_drive(2'b11, 8'h00);
      spi_end();
      n = 1;
      while (!tx_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("spi_rd_latency", n, 32'd4);
      check("spi_rd_data", {24'd0, tx_data}, 32'hA5);
      @(negedge clk);
      check("spi_rd_pulse", {31'd0, tx_valid}, 32'd0);
      check("spi_wr_acc", get(0), mk(1'b0, 1'b1, 8'h10, 8'hA5));
      check("spi_rd_acc", get(1) >> 8, mk(1'b0, 1'b0, 8'h10, 8'h00) >> 8);
      idle(2);

      // local read of 0x10
      tx0 = tx_cnt;
      @(negedge clk);
      loc_set(1'b0, 8'h10, 8'h00);
      @(negedge clk);
      check("loc_gnt_c1", {31'd0, loc_gnt}, 32'd1);
      loc_req = 1'b0;
      @(negedge clk);
      check("loc_gnt_c2", {30'd0, loc_gnt, loc_rvalid}, 32'd0);
      @(negedge clk);
      check("loc_rvalid_c3", {31'd0, loc_rvalid}, 32'd1);
      check("loc_rdata", {24'd0, loc_rdata}, 32'hA5);
      @(negedge clk);
      check("loc_rvalid_c4", {31'd0, loc_rvalid}, 32'd0);
      check("loc_no_tx", tx_cnt, tx0);

      // write address wrap 0xFF -> 0x00 with back-to-back writes
      spi_cmd(2'b00, 8'hFF);
      acc_q.delete();
      spi_drive(2'b01, 8'h5A);
      spi_drive(2'b01, 8'h6B);
      spi_end();
      idle(8);
      check("wrap_count", acc_q.size(), 32'd2);
      check("wrap_ff", get(0), mk(1'b0, 1'b1, 8'hFF, 8'h5A));
      check("wrap_00", get(1), mk(1'b0, 1'b1, 8'h00, 8'h6B));
      check("wrap_no_ovf", {31'd0, ovf}, 32'd0);

      // overflow while local holds the port; rd_addr is 0x11 here
      acc_q.delete();
      @(negedge clk);
      loc_set(1'b0, 8'h10, 8'h00);
      @(negedge clk);
      check("ovf_loc_gnt", {31'd0, loc_gnt}, 32'd1);
      loc_req  = 1'b0;
      rx_valid = 1'b1;
      rx_data  = {2'b11, 8'h00};
      @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      idle(8);
      check("ovf_set", {31'd0, ovf}, 32'd1);
      check("ovf_count", acc_q.size(), 32'd2);
      check("ovf_loc_acc", get(0) >> 8, mk(1'b1, 1'b0, 8'h10, 8'h00) >> 8);
      check("ovf_spi_acc", get(1) >> 8, mk(1'b0, 1'b0, 8'h11, 8'h00) >> 8);
      spi_cmd(2'b11, 8'h00);
      idle(8);
      check("ovf_rd_addr", get(2) >> 8, mk(1'b0, 1'b0, 8'h12, 8'h00) >> 8);

      // reset during an SPI read access
      spi_cmd(2'b10, 8'h10);
      tx0 = tx_cnt;
      spi_drive(2'b11, 8'h00);
      spi_end();
      n = 0;
      while (!mem_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_acc_seen", {31'd0, mem_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_strobes", {26'd0, mem_en, mem_we, loc_gnt, tx_valid, loc_rvalid, ovf},
            32'd0);
      check("rst_mid_data", {tx_data, loc_rdata, mem_addr, mem_wdata}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      check("rst_no_tx", tx_cnt, tx0);
      acc_q.delete();
      spi_cmd(2'b01, 8'h77);
      spi_cmd(2'b11, 8'h00);
      idle(8);
      check("post_rst_wr", get(0), mk(1'b0, 1'b1, 8'h00, 8'h77));
      check("post_rst_rd", get(1) >> 8, mk(1'b0, 1'b0, 8'h00, 8'h00) >> 8);
      check("post_rst_data", {24'd0, tx_data}, 32'h77);
      check("post_rst_tx", tx_cnt, tx0 + 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; SHALL equal 8 for SPI-driven addressing.
REQ-002 Parameter DATA_W, default 8, memory data width; SHALL equal 8.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  10  SPI slave word: [9:8] command, [7:0] payload.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 tx_data  output  8  read data returned to SPI slave.
REQ-008 tx_valid  output  1  one-cycle strobe qualifying tx_data.
REQ-009 loc_req  input  1  local requester access request; held until granted.
REQ-010 loc_we  input  1  local request type: 1 write, 0 read.
REQ-011 loc_addr  input  ADDR_W  local request address.
REQ-012 loc_wdata  input  DATA_W  local write data.
REQ-013 loc_gnt  output  1  one-cycle grant; local request consumed this cycle.
REQ-014 loc_rdata  output  DATA_W  local read data.
REQ-015 loc_rvalid  output  1  one-cycle strobe qualifying loc_rdata.
REQ-016 mem_en, mem_we  output  1 each  single-port memory enable / write enable.
REQ-017 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W, valid one cycle after mem_en with mem_we=0.
REQ-018 ovf  output  1  sticky SPI command overflow flag.

Function
REQ-019 Commands on rx_valid: 00 load wr_addr<=payload; 01 write payload at wr_addr; 10 load rd_addr<=payload; 11 read at rd_addr.
REQ-020 Commands 00/10 SHALL update the address register at the sampling edge, without memory access or arbitration.
REQ-021 Commands 01/11 SHALL be captured at the sampling edge into a one-entry pending buffer (type, address snapshot, data); the relevant address register SHALL post-increment modulo 256 (255 -> 0).
REQ-022 Command 01/11 arriving while the buffer is full and not being drained on that same edge SHALL be dropped, with no address increment, and SHALL set ovf; ovf clears only on reset.
REQ-023 FSM states IDLE, SPI_ACC, LOC_ACC, RD_RET; a single memory access per pass.
REQ-024 IDLE: SPI pending alone -> SPI_ACC; loc_req alone -> LOC_ACC; both -> round-robin, the requester not granted last wins; neither -> stay IDLE.
REQ-025 The round-robin pointer SHALL update on each grant; after reset SPI wins the first tie.
REQ-026 Entering SPI_ACC SHALL free the pending buffer at that edge; a new 01/11 capture on that same edge SHALL be accepted.
REQ-027 SPI_ACC/LOC_ACC: mem_en=1, mem_we/mem_addr/mem_wdata from the granted request; loc_gnt=1 only in LOC_ACC; writes -> IDLE, reads -> RD_RET.
REQ-028 RD_RET: capture mem_rdata into tx_data (SPI owner) or loc_rdata (local owner); the matching valid SHALL pulse for exactly the next cycle; -> IDLE.
REQ-029 Uncontended SPI read: rx_valid in cycle 0 -> mem_en in cycle 2 -> tx_valid in cycle 4; uncontended local read: loc_req in cycle 0 -> loc_gnt in cycle 1 -> loc_rvalid in cycle 3.
REQ-030 Outside their access states mem_en, mem_we and loc_gnt SHALL be 0; tx_data/loc_rdata hold their last value.

Reset
REQ-031 On rst_n low, immediately: state IDLE, pending buffer empty, wr_addr=rd_addr=0, round-robin pointer = local, all outputs 0, ovf=0.
REQ-032 Reset mid-access SHALL abandon the access with no valid strobe after release.

Verification
REQ-033 SPI 00 0x10, 01 0xA5, 10 0x10, 11 -> mem write 0xA5 at 0x10; tx_data=0xA5, tx_valid in cycle 4 after the 11 strobe.
REQ-034 wr_addr=0xFF, two 01 writes -> accesses at 0xFF then 0x00.
REQ-035 SPI pending and loc_req in the same IDLE cycle, twice -> SPI granted first, local second, then SPI next tie.
REQ-036 Two 11 commands on consecutive cycles while local holds the port -> second dropped, ovf=1, rd_addr incremented once.
REQ-037 Local read of 0x10 after REQ-033 -> loc_gnt one cycle, loc_rvalid two cycles later with loc_rdata=0xA5, tx_valid stays 0.
REQ-038 rst_n asserted during SPI_ACC read -> no tx_valid; all outputs 0; first access after release is correct.
